// File: rtl/lcd_pkg.sv
// ============================================================================
// Module  : lcd_pkg
// Brief   : Shared types, bit positions and helpers for the HD44780 LCD
//           controller. Optional power-on init: LCD_POWERON_INIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
`ifdef LCD_POWERON_INIT_EN
        ST_EXEC      = 3'd4,
        ST_INIT_WAIT = 3'd5,
        ST_INIT_CMD  = 3'd6
`else
        ST_EXEC  = 3'd4
`endif
    } state_t;

    localparam int ON_BIT    = 31;
    localparam int START_BIT = 10;
    localparam int RS_BIT    = 9;
    localparam int RW_BIT    = 8;
    localparam int DATA_LSB  = 0;
    localparam int DATA_W    = 8;

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

`ifdef LCD_POWERON_INIT_EN
    localparam int INIT_WAIT_CYC = 750000;
    localparam int INIT_CMD_N    = 4;
    // Byte i holds init command i: 0x38, 0x0C, 0x01, 0x06.
    localparam logic [31:0] INIT_ROM = 32'h06_01_0C_38;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        return INIT_ROM[idx*8 +: 8];
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/lcd_timer.sv
// ============================================================================
// Module  : lcd_timer
// Brief   : Loadable down-counter with zero flag; holds at zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_timer #(
    parameter int               CNT_W   = 17,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_ctrl.sv
// ============================================================================
// Module  : lcd_ctrl
// Brief   : Turns START toggles in the LSU LCD word into timed HD44780 write
//           cycles. Optional power-on init sequence: LCD_POWERON_INIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000,
    parameter int CNT_W         = 17
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_busy,
    output logic        o_lcd_done
);

`ifdef LCD_POWERON_INIT_EN
    localparam int INIT_TMR_W = $clog2(INIT_WAIT_CYC);
    localparam int TMR_W      = (CNT_W > INIT_TMR_W) ? CNT_W : INIT_TMR_W;
    localparam logic [TMR_W-1:0] TMR_RST = TMR_W'(INIT_WAIT_CYC - 1);
`else
    localparam int TMR_W = CNT_W;
    localparam logic [TMR_W-1:0] TMR_RST = '0;
`endif

    state_t            state;
    logic              start_seen;
    logic              en;
    logic              rs;
    logic [7:0]        data;
    logic              busy;
    logic              done;
    logic              lcd_on;
`ifdef LCD_POWERON_INIT_EN
    logic              in_init;
    logic [2:0]        init_idx;
`endif

    logic              req;
    logic              long_cmd;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;
    logic              unused_bits;

    assign req         = (i_lcd_reg[START_BIT] != start_seen);
    assign long_cmd    = is_long_cmd(rs, data);
    assign unused_bits = ^{i_lcd_reg[30:11], i_lcd_reg[RW_BIT]};

    // Timer is reloaded on the edge that enters each timed state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PULSE_CYC - 1);
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = long_cmd ? TMR_W'(LONG_EXEC_CYC - 1) : TMR_W'(EXEC_CYC - 1);
                end
            end
`ifdef LCD_POWERON_INIT_EN
            ST_INIT_CMD: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(SETUP_CYC - 1);
            end
`endif
            default: ;
        endcase
    end

    lcd_timer #(
        .CNT_W   (TMR_W),
        .RST_VAL (TMR_RST)
    ) u_timer (
        .clk      (i_clk),
        .rst_n    (i_reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            start_seen <= 1'b0;
            en         <= 1'b0;
            rs         <= 1'b0;
            data       <= 8'h00;
            done       <= 1'b0;
            lcd_on     <= 1'b0;
`ifdef LCD_POWERON_INIT_EN
            state      <= ST_INIT_WAIT;
            busy       <= 1'b1;
            in_init    <= 1'b1;
            init_idx   <= 3'd0;
`else
            state      <= ST_IDLE;
            busy       <= 1'b0;
`endif
        end else begin
            lcd_on <= i_lcd_reg[ON_BIT];
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        rs         <= i_lcd_reg[RS_BIT];
                        data       <= i_lcd_reg[DATA_LSB +: DATA_W];
                        start_seen <= i_lcd_reg[START_BIT];
                        busy       <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) begin
                        en    <= 1'b1;
                        state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_zero) begin
                        en    <= 1'b0;
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (tmr_zero) begin
`ifdef LCD_POWERON_INIT_EN
                        if (in_init && init_idx != 3'(INIT_CMD_N)) begin
                            state <= ST_INIT_CMD;
                        end else if (in_init) begin
                            // Init completion is silent: no done pulse.
                            in_init <= 1'b0;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
`endif
                    end
                end
`ifdef LCD_POWERON_INIT_EN
                ST_INIT_WAIT: begin
                    if (tmr_zero) begin
                        state <= ST_INIT_CMD;
                    end
                end
                ST_INIT_CMD: begin
                    rs       <= 1'b0;
                    data     <= init_cmd(init_idx[1:0]);
                    init_idx <= init_idx + 3'd1;
                    state    <= ST_SETUP;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_lcd_on   = lcd_on;
    assign o_lcd_en   = en;
    assign o_lcd_rs   = rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data;
    assign o_lcd_busy = busy;
    assign o_lcd_done = done;

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
// ============================================================================
// Module  : tb_lcd_ctrl
// Brief   : Self-checking bench for lcd_ctrl (default build, short timings).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_ctrl;

    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int HOLD  = 2;
    localparam int EXEC  = 10;
    localparam int LEXEC = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] lcd_reg = 32'h0;
    logic        o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_busy, o_lcd_done;
    logic [7:0]  o_lcd_data;

    int n_total = 0;
    int n_pass  = 0;

    lcd_ctrl #(
        .SETUP_CYC     (SETUP),
        .PULSE_CYC     (PULSE),
        .HOLD_CYC      (HOLD),
        .EXEC_CYC      (EXEC),
        .LONG_EXEC_CYC (LEXEC),
        .CNT_W         (17)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_lcd_reg  (lcd_reg),
        .o_lcd_on   (o_lcd_on),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_data (o_lcd_data),
        .o_lcd_busy (o_lcd_busy),
        .o_lcd_done (o_lcd_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: a transfer is just an elapsed-cycle count
    // against its total length; outputs follow from where that count sits.
    logic       m_on = 0, m_seen = 0, m_busy = 0, m_rs = 0, m_done = 0;
    logic [7:0] m_data = 0;
    int         m_el = 0, m_len = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on = 0; m_seen = 0; m_busy = 0; m_rs = 0; m_done = 0;
            m_data = 0; m_el = 0; m_len = 0;
        end else begin
            m_on   = lcd_reg[31];
            m_done = 0;
            if (m_busy) begin
                m_el++;
                if (m_el == m_len) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (lcd_reg[10] != m_seen) begin
                m_seen = lcd_reg[10];
                m_busy = 1;
                m_el   = 0;
                m_rs   = lcd_reg[9];
                m_data = lcd_reg[7:0];
                m_len  = SETUP + PULSE + HOLD +
                         ((!lcd_reg[9] && lcd_reg[7:0] inside {8'h01, 8'h02, 8'h03}) ? LEXEC : EXEC);
            end
        end
    end

    always @(negedge clk) begin
        logic m_en;
        m_en = m_busy && (m_el >= SETUP) && (m_el < SETUP + PULSE);
        check("cycle",
              {18'd0, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_busy, o_lcd_done},
              {18'd0, m_on, m_en, m_rs, 1'b0, m_data, m_busy, m_done});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic toggle(input logic rs, input logic [7:0] d);
        tick();
        lcd_reg[10]  = ~lcd_reg[10];
        lcd_reg[9]   = rs;
        lcd_reg[7:0] = d;
    endtask

    task automatic toggle_bit();
        tick();
        lcd_reg[10] = ~lcd_reg[10];
    endtask

    // Waits for busy, then profiles the transfer at negedges.
    task automatic measure(output int wait_c, output int busy_len, output int en_len,
                           output int en_off, output int done_cnt);
        wait_c = 0; busy_len = 0; en_len = 0; en_off = -1; done_cnt = 0;
        do begin
            @(negedge clk);
            wait_c++;
        end while (!o_lcd_busy && wait_c < 50);
        check("busy_rise", {31'd0, o_lcd_busy}, 32'd1);
        while (o_lcd_busy && busy_len < 500) begin
            busy_len++;
            if (o_lcd_en) begin
                if (en_len == 0) en_off = busy_len - 1;
                en_len++;
            end
            if (o_lcd_done) done_cnt++;
            @(negedge clk);
        end
        if (o_lcd_done) done_cnt++;
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         len;
    } cmd_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, bl, el, eo, dc;
        int w2, bl2, el2, eo2, dc2;
        int bc;
        cmd_t cmds[7];
        cmds[0] = '{1'b0, 8'h01, 38};
        cmds[1] = '{1'b0, 8'h02, 38};
        cmds[2] = '{1'b0, 8'h03, 38};
        cmds[3] = '{1'b0, 8'h38, 18};
        cmds[4] = '{1'b0, 8'h04, 18};
        cmds[5] = '{1'b1, 8'h01, 18};
        cmds[6] = '{1'b0, 8'h00, 18};

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs",
              {18'd0, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_busy, o_lcd_done},
              32'd0);
        rst_n = 1'b1;

        // ON bit latency
        tick();
        lcd_reg[31] = 1'b1;
        @(negedge clk);
        check("on_before_edge", {31'd0, o_lcd_on}, 32'd0);
        @(negedge clk);
        check("on_latency", {31'd0, o_lcd_on}, 32'd1);

        // Data write with DATA changed mid-PULSE (no toggle)
        toggle(1'b1, 8'h41);
        fork
            measure(w, bl, el, eo, dc);
            begin
                repeat (4) tick();
                lcd_reg[7:0] = 8'h55;
            end
        join
        check("data_busy_len", bl, 18);
        check("data_en_len", el, 4);
        check("data_en_offset", eo, 2);
        check("data_done_cnt", dc, 1);
        check("data_held", {24'd0, o_lcd_data}, 32'h41);
        check("rs_held", {31'd0, o_lcd_rs}, 32'd1);
        check("rw_zero", {31'd0, o_lcd_rw}, 32'd0);
        repeat (5) tick();
        check("no_new_xfer", {31'd0, o_lcd_busy}, 32'd0);

        // Long vs normal exec lengths
        foreach (cmds[i]) begin
            toggle(cmds[i].rs, cmds[i].d);
            measure(w, bl, el, eo, dc);
            check($sformatf("busy_len_rs%0d_%02h", cmds[i].rs, cmds[i].d), bl, cmds[i].len);
        end

        // Toggle while busy: served right after IDLE
        toggle(1'b1, 8'h41);
        fork
            measure(w, bl, el, eo, dc);
            begin
                repeat (10) tick();
                toggle(1'b1, 8'h42);
            end
        join
        check("first_busy_len", bl, 18);
        check("first_data", {24'd0, o_lcd_data}, 32'h41);
        measure(w2, bl2, el2, eo2, dc2);
        check("pending_gap", w2, 1);
        check("pending_busy_len", bl2, 18);
        check("pending_en_len", el2, 4);
        check("pending_data", {24'd0, o_lcd_data}, 32'h42);

        // Double toggle while busy cancels out
        toggle(1'b1, 8'h43);
        fork
            measure(w, bl, el, eo, dc);
            begin
                repeat (6) tick();
                toggle_bit();
                toggle_bit();
            end
        join
        check("dbl_first_len", bl, 18);
        bc = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_lcd_busy) bc++;
        end
        check("dbl_no_second", bc, 0);

        // Async reset during PULSE
        toggle(1'b1, 8'h41);
        repeat (3) tick();
        check("pre_reset_en", {31'd0, o_lcd_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_en", {31'd0, o_lcd_en}, 32'd0);
        check("async_rst_busy", {31'd0, o_lcd_busy}, 32'd0);
        check("async_rst_data", {24'd0, o_lcd_data}, 32'h0);
        lcd_reg[10] = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        bc = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_lcd_busy) bc++;
        end
        check("post_rst_idle", bc, 0);
        tick();
        lcd_reg[10]  = 1'b1;
        lcd_reg[9]   = 1'b1;
        lcd_reg[7:0] = 8'h44;
        measure(w, bl, el, eo, dc);
        check("post_rst_xfer_len", bl, 18);
        check("post_rst_data", {24'd0, o_lcd_data}, 32'h44);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Consumes the 32-bit LCD control word written by the load-store unit (the `o_io_lcd` register) and drives an HD44780-compatible character LCD.
- Software requests one transfer by toggling the START bit. The block then generates setup, enable-pulse, hold and execution-wait timing.
- Exposes busy/done status for a future readable status address.
- Sits between the LSU output register and the board LCD pins.

Parameters:
- SETUP_CYC, 2, cycles RS/DATA are stable before EN rises (≥40 ns at 50 MHz).
- PULSE_CYC, 12, cycles EN is held high (≥230 ns).
- HOLD_CYC, 2, cycles RS/DATA are held after EN falls.
- EXEC_CYC, 2000, wait after a normal command or data write (40 us).
- LONG_EXEC_CYC, 82000, wait after clear/home commands (1.64 ms).
- CNT_W, 17, timer width; must hold LONG_EXEC_CYC.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-low reset
- i_lcd_reg  in  32  LSU LCD word: [31] ON, [10] START toggle, [9] RS, [8] RW, [7:0] DATA
- o_lcd_on  out  1  LCD power/backlight enable
- o_lcd_en  out  1  LCD E strobe
- o_lcd_rs  out  1  LCD register select
- o_lcd_rw  out  1  LCD R/W; always 0 (write-only)
- o_lcd_data  out  8  LCD data bus
- o_lcd_busy  out  1  transfer in progress
- o_lcd_done  out  1  one-cycle pulse when a transfer completes

Behaviour:
- Clock and reset: single clock i_clk. i_reset is asynchronous and active-low.
- Reset values: all outputs 0; start_seen=0; state=IDLE; timer=0.
- Request detection: a request exists when i_lcd_reg[10] != start_seen.
- States: IDLE, SETUP, PULSE, HOLD, EXEC.
- IDLE with request, on the accepting edge:
  - latch rs=i_lcd_reg[9] and data=i_lcd_reg[7:0];
  - start_seen <= i_lcd_reg[10];
  - busy <= 1;
  - timer <= SETUP_CYC-1;
  - go to SETUP.
- Timer: loaded on each state entry, decrements every cycle; the state advances on the cycle the timer reads 0. Each state therefore lasts exactly its parameter count (minimum 1).
- SETUP: en=0, rs/data driven from the latched values. Next state PULSE.
- PULSE: en=1 for PULSE_CYC cycles. Next state HOLD.
- HOLD: en=0, rs/data still held. Next state EXEC.
- EXEC length:
  - LONG_EXEC_CYC if rs=0 and data is 0x01, 0x02 or 0x03;
  - otherwise EXEC_CYC.
- EXEC exit: on the exit edge busy <= 0, done <= 1 for one cycle, go to IDLE.
- Total busy time: SETUP_CYC + PULSE_CYC + HOLD_CYC + exec cycles. Busy rises on the edge after the toggle is sampled.
- START toggles while busy are not accepted. start_seen is unchanged, so one pending toggle is served immediately after return to IDLE.
- Two toggles while busy cancel each other (net no change). Software must poll busy before toggling.
- Changes to i_lcd_reg RS/DATA during a transfer are ignored; the latched copies are used.
- o_lcd_on is a registered copy of i_lcd_reg[31], one cycle latency, independent of state.
- o_lcd_rw is tied to 0. i_lcd_reg[8] is ignored.
- Reset mid-transfer: outputs return to 0 immediately (en drops asynchronously) and the transfer is discarded. After reset, a toggle bit of 1 in i_lcd_reg counts as a request.
- o_lcd_data/o_lcd_rs keep their last latched values in IDLE.

Optional Feature:
- Macro: LCD_POWERON_INIT_EN.
- Defined:
  - after reset, busy=1 and the block waits 750000 cycles (15 ms);
  - it then issues the internal commands 0x38, 0x0C, 0x01, 0x06 (rs=0) through the normal SETUP..EXEC path;
  - busy falls after the last EXEC;
  - no done pulse during init;
  - START toggles during init stay pending.
- Not defined: the block enters IDLE directly after reset with busy=0.

Decomposition:
- Package lcd_pkg:
  - state enum (including INIT_WAIT/INIT_CMD under the macro);
  - bit-position localparams for ON/START/RS/RW/DATA;
  - function is_long_cmd(rs, data);
  - init command ROM constant.
- One sub-module, lcd_timer: loadable down-counter with zero flag, width CNT_W.

Test Plan (sim params SETUP_CYC=2, PULSE_CYC=4, HOLD_CYC=2, EXEC_CYC=10, LONG_EXEC_CYC=30):
- Data write: toggle bit10 with RS=1, DATA=0x41 -> en high exactly 4 cycles, starting 2 cycles after busy rises; data=0x41 and rs=1 stable from SETUP through HOLD; busy high 18 cycles; done pulses once.
- Clear command: RS=0, DATA=0x01 -> busy high 38 cycles. DATA=0x38 -> busy high 18 cycles.
- Toggle while busy: second toggle (DATA=0x42) issued mid-EXEC -> first completes unchanged; second starts the cycle after IDLE is reached and outputs 0x42. Double toggle while busy -> no second transfer.
- Data change without toggle: modify DATA to 0x55 mid-PULSE -> o_lcd_data stays 0x41; no new transfer.
- Async reset asserted during PULSE -> en, busy and data drop to 0 without a clock edge; after release, no transfer unless bit10 != 0.
- ON bit: set i_lcd_reg[31]=1 -> o_lcd_on=1 one cycle later, also while busy. With LCD_POWERON_INIT_EN: four EN pulses with data 0x38, 0x0C, 0x01, 0x06 in order before busy falls.
